// File: rtl/dcache_pkg.sv
// Shared definitions for the write-through data cache: RISC-V func3 codes,
// controller state encoding and the byte-strobe / alignment helpers.
package dcache_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } dc_state_t;

    // Byte-lane enables for a store; unlisted store encodings give no lanes,
    // which the controller treats as a no-op.
    function automatic logic [3:0] calc_wstrb(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return 4'b0011 << off;
            F3_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Halves need an even offset, words need offset 0. Unlisted load
    // encodings behave as LW; unlisted store encodings are never misaligned.
    function automatic logic is_misaligned(input logic we, input logic [2:0] f3,
                                           input logic [1:0] off);
        logic half;
        logic word;
        half = (f3 == F3_H) || (!we && f3 == F3_HU);
        word = (f3 == F3_W) ||
               (!we && !(f3 inside {F3_B, F3_H, F3_BU, F3_HU}));
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dcache_load_align.sv
// Load result formatter: picks the addressed byte/half out of a cache word
// and sign- or zero-extends it according to func3.
module dcache_load_align
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            offset,
    input  logic [2:0]            func3,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    // Lane select then extension; anything not byte/half returns the word.
    always_comb begin
        case (offset)
            2'd0:    sel_b = word[7:0];
            2'd1:    sel_b = word[15:8];
            2'd2:    sel_b = word[23:16];
            default: sel_b = word[31:24];
        endcase
        sel_h = offset[1] ? word[31:16] : word[15:0];
        case (func3)
            F3_B:    rdata = {{(DATA_WIDTH-8){sel_b[7]}}, sel_b};
            F3_BU:   rdata = {{(DATA_WIDTH-8){1'b0}}, sel_b};
            F3_H:    rdata = {{(DATA_WIDTH-16){sel_h[15]}}, sel_h};
            F3_HU:   rdata = {{(DATA_WIDTH-16){1'b0}}, sel_h};
            default: rdata = word;
        endcase
    end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per
// line. Load hits return in the request cycle; load misses fill through FILL,
// every store goes to memory through WRITE.
// Optional build macro DCACHE_WT_STATS_EN adds load hit/miss counters.
module dcache_wt
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int SETS       = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [2:0]            cpu_func3,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    output logic                  cpu_misaligned,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int IW = $clog2(SETS);
    localparam int TW = ADDR_WIDTH - IW - 2;

    dc_state_t state, state_nxt;

    logic [SETS-1:0]       valid;
    logic [TW-1:0]         tag_arr  [SETS];
    logic [DATA_WIDTH-1:0] data_arr [SETS];

    logic [IW-1:0]         idx, fidx;
    logic [TW-1:0]         tag, ftag;
    logic [1:0]            off;
    logic                  hit, wr_hit, misal;
    logic [3:0]            st_strb;
    logic [DATA_WIDTH-1:0] st_wdata, rd_word;
    logic                  start_fill, start_write;
    logic                  st_done;

    // Request-side fields; the in-flight transaction is addressed from the
    // registered mem_addr so the update does not depend on the core's bus.
    assign idx    = cpu_addr[IW+1:2];
    assign tag    = cpu_addr[ADDR_WIDTH-1:IW+2];
    assign off    = cpu_addr[1:0];
    assign fidx   = mem_addr[IW+1:2];
    assign ftag   = mem_addr[ADDR_WIDTH-1:IW+2];
    assign hit    = valid[idx] && (tag_arr[idx] == tag);
    assign wr_hit = valid[fidx] && (tag_arr[fidx] == ftag);
    assign misal  = cpu_req && is_misaligned(cpu_we, cpu_func3, off);
    assign st_strb = calc_wstrb(cpu_func3, off);
    assign rd_word = data_arr[idx];

    assign cpu_misaligned = misal;

    // Replicate store data so every enabled lane carries the right byte.
    always_comb begin
        case (cpu_func3)
            F3_B:    st_wdata = {4{cpu_wdata[BYTE_WIDTH-1:0]}};
            F3_H:    st_wdata = {2{cpu_wdata[2*BYTE_WIDTH-1:0]}};
            default: st_wdata = cpu_wdata;
        endcase
    end

    dcache_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .word   (rd_word),
        .offset (off),
        .func3  (cpu_func3),
        .rdata  (cpu_rdata)
    );

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and stall. st_done marks the cycle right after a store ack,
    // where the still-held store request is retired instead of re-issued.
    always_comb begin
        state_nxt   = state;
        cpu_stall   = 1'b0;
        start_fill  = 1'b0;
        start_write = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req && !misal) begin
                    if (!cpu_we) begin
                        if (!hit) begin
                            cpu_stall  = 1'b1;
                            start_fill = 1'b1;
                            state_nxt  = FILL;
                        end
                    end else if (st_strb != 4'b0000 && !st_done) begin
                        cpu_stall   = 1'b1;
                        start_write = 1'b1;
                        state_nxt   = WRITE;
                    end
                end
            end
            FILL, WRITE: begin
                cpu_stall = cpu_req;
                if (mem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One-cycle flag: the store just acknowledged is complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st_done <= 1'b0;
        else     st_done <= (state == WRITE) && mem_ack;
    end

    // Memory-side request registers; address/data are captured on leaving IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
        end else if (start_fill) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wstrb <= 4'b0000;
        end else if (start_write) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata <= st_wdata;
            mem_wstrb <= st_strb;
        end else if ((state == FILL || state == WRITE) && mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    // Valid bits: set on fill completion, all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           valid       <= '0;
        else if (state == FILL && mem_ack) valid[fidx] <= 1'b1;
    end

    // Tag/data arrays (no reset): fill the line, or merge a store hit.
    always_ff @(posedge clk) begin
        if (state == FILL && mem_ack) begin
            tag_arr[fidx]  <= ftag;
            data_arr[fidx] <= mem_rdata;
        end else if (state == WRITE && mem_ack && wr_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b])
                    data_arr[fidx][b*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

`ifdef DCACHE_WT_STATS_EN
    // Load statistics: hits are zero-wait IDLE load cycles, misses are fill starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && cpu_req && !cpu_we && !misal && hit)
                hit_count <= hit_count + 32'd1;
            if (start_fill)
                miss_count <= miss_count + 32'd1;
        end
    end
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule
